// File: rtl/aec_pkg.sv
// Shared types and helpers for the streaming infix evaluator.
// The package holds character codes, operator, error and state encodings.
package aec_pkg;

   localparam logic [7:0] CH_PLUS  = 8'h2b;
   localparam logic [7:0] CH_MINUS = 8'h2d;
   localparam logic [7:0] CH_STAR  = 8'h2a;
   localparam logic [7:0] CH_LPAR  = 8'h28;
   localparam logic [7:0] CH_RPAR  = 8'h29;
   localparam logic [7:0] CH_EQ    = 8'h3d;

   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_LPAR} op_e;
   typedef enum logic [1:0] {ERR_OVERFLOW, ERR_BAD_CHAR, ERR_PAREN, ERR_SYNTAX} err_e;
   typedef enum logic [2:0] {IDLE, ACCEPT, REDUCE, FINAL, DRAIN, DONE} state_e;

   function automatic logic prec(op_e op);
      return (op == OP_MUL);
   endfunction

   function automatic logic is_hex(logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66);
   endfunction

   // 'a'..'f' have low nibble 1..6, so adding 9 maps them to 10..15.
   function automatic logic [3:0] hex_val(logic [7:0] c);
      if (c <= 8'h39) return c[3:0];
      else            return c[3:0] + 4'd9;
   endfunction

endpackage

// File: rtl/aec_lifo.sv
// Stack with push, pop, replace-top and a combined pop-and-replace used to
// collapse two operands into one result in a single cycle.
module aec_lifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic          wr_top,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  top,
   output logic [W-1:0]  top2,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [CW-1:0] cnt;
   logic          we;
   logic [AW-1:0] waddr;

   assign count = cnt;
   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);
   assign top   = empty ? '0 : mem[AW'(cnt - CW'(1))];
   assign top2  = (cnt >= CW'(2)) ? mem[AW'(cnt - CW'(2))] : '0;

   // NOTE: every variable gets a default before the branches so no latch is inferred.
   always_comb begin
      we    = 1'b0;
      waddr = '0;
      if (push && !full) begin
         we    = 1'b1;
         waddr = AW'(cnt);
      end else if (pop && wr_top && cnt >= CW'(2)) begin
         we    = 1'b1;
         waddr = AW'(cnt - CW'(2));
      end else if (wr_top && !pop && !empty) begin
         we    = 1'b1;
         waddr = AW'(cnt - CW'(1));
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clear)        cnt <= '0;
      else if (push && !full)  cnt <= cnt + CW'(1);
      else if (pop && !empty)  cnt <= cnt - CW'(1);
   end

   // NOTE: storage is not reset; the count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= din;
   end

endmodule

// File: rtl/aec_stream_eval.sv
// Streaming shunting-yard evaluator: one ASCII char per handshake, two stacks,
// result (or error code) presented with valid/ready after '='.
module aec_stream_eval
   import aec_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 16,
   parameter bit MULTI_DIGIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              out_err,
   output logic [1:0]        err_code
);

   localparam int CW = $clog2(DEPTH + 1);

   state_e state, state_nxt;
   logic   prev_digit, digit_nxt;
   op_e    pend_op, pend_op_nxt;
   logic   pend_rpar, pend_rpar_nxt;
   logic   err_valid, err_set;
   err_e   err_q, err_new;
   logic   fire, is_op_ch, do_reduce, reduce_ch, reduce_pend;
   op_e    ch_op;

   logic              clear, op_push, op_pop, op_full, op_empty;
   op_e               op_din, op_top;
   logic [1:0]        op_top_raw, op_top2_unused;
   logic [CW-1:0]     op_count_unused;
   logic              val_push, val_pop, val_wr, val_full, val_empty_unused;
   logic [DATA_W-1:0] val_din, val_top, val_top2, red_val;
   logic [CW-1:0]     val_count;

   aec_lifo #(.W(2), .DEPTH(DEPTH)) u_op_stack (
      .clk(clk), .rst(rst), .clear(clear), .push(op_push), .pop(op_pop), .wr_top(1'b0),
      .din(op_din), .top(op_top_raw), .top2(op_top2_unused), .count(op_count_unused),
      .full(op_full), .empty(op_empty)
   );

   aec_lifo #(.W(DATA_W), .DEPTH(DEPTH)) u_val_stack (
      .clk(clk), .rst(rst), .clear(clear), .push(val_push), .pop(val_pop), .wr_top(val_wr),
      .din(val_din), .top(val_top), .top2(val_top2), .count(val_count),
      .full(val_full), .empty(val_empty_unused)
   );

   assign op_top    = op_e'(op_top_raw);
   assign in_ready  = !rst && (state == ACCEPT || state == DRAIN);
   assign fire      = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign out_err   = out_valid && err_valid;
   assign err_code  = out_err ? 2'(err_q) : 2'b00;
   assign result    = (out_valid && !err_valid) ? val_top : '0;

   always_comb begin
      is_op_ch = 1'b1;
      ch_op    = OP_ADD;
      case (in_data)
         CH_PLUS:  ch_op = OP_ADD;
         CH_MINUS: ch_op = OP_SUB;
         CH_STAR:  ch_op = OP_MUL;
         default:  is_op_ch = 1'b0;
      endcase
   end

   always_comb begin
      case (op_top)
         OP_ADD:  red_val = val_top2 + val_top;
         OP_SUB:  red_val = val_top2 - val_top;
         default: red_val = val_top2 * val_top;
      endcase
   end

   assign reduce_ch   = !op_empty && op_top != OP_LPAR && (prec(op_top) >= prec(ch_op));
   assign reduce_pend = !op_empty && op_top != OP_LPAR && (prec(op_top) >= prec(pend_op));

   always_comb begin
      state_nxt     = state;
      digit_nxt     = prev_digit;
      pend_op_nxt   = pend_op;
      pend_rpar_nxt = pend_rpar;
      clear         = 1'b0;
      op_push       = 1'b0;
      op_pop        = 1'b0;
      op_din        = OP_LPAR;
      val_push      = 1'b0;
      val_pop       = 1'b0;
      val_wr        = 1'b0;
      val_din       = '0;
      err_set       = 1'b0;
      err_new       = ERR_OVERFLOW;
      do_reduce     = 1'b0;

      case (state)
         IDLE: begin
            clear         = 1'b1;
            digit_nxt     = 1'b0;
            pend_rpar_nxt = 1'b0;
            state_nxt     = ACCEPT;
         end
         ACCEPT: if (fire) begin
            digit_nxt = 1'b0;
            if (is_hex(in_data)) begin
               digit_nxt = 1'b1;
               if (prev_digit && MULTI_DIGIT) begin
                  val_wr  = 1'b1;
                  val_din = (val_top << 4) | DATA_W'(hex_val(in_data));
               end else if (prev_digit) begin
                  err_set = 1'b1;
                  err_new = ERR_SYNTAX;
               end else if (val_full) begin
                  err_set = 1'b1;
               end else begin
                  val_push = 1'b1;
                  val_din  = DATA_W'(hex_val(in_data));
               end
            end else if (is_op_ch) begin
               pend_op_nxt   = ch_op;
               pend_rpar_nxt = 1'b0;
               if (reduce_ch)    state_nxt = REDUCE;
               else if (op_full) err_set = 1'b1;
               else begin
                  op_push = 1'b1;
                  op_din  = ch_op;
               end
            end else if (in_data == CH_LPAR) begin
               if (op_full) err_set = 1'b1;
               else         op_push = 1'b1;
            end else if (in_data == CH_RPAR) begin
               if (op_empty) begin
                  err_set = 1'b1;
                  err_new = ERR_PAREN;
               end else begin
                  pend_rpar_nxt = 1'b1;
                  state_nxt     = REDUCE;
               end
            end else if (in_data == CH_EQ) begin
               state_nxt = FINAL;
            end else begin
               err_set = 1'b1;
               err_new = ERR_BAD_CHAR;
            end
         end
         REDUCE: begin
            if (pend_rpar) begin
               if (op_empty) begin
                  err_set = 1'b1;
                  err_new = ERR_PAREN;
               end else if (op_top == OP_LPAR) begin
                  op_pop        = 1'b1;
                  pend_rpar_nxt = 1'b0;
                  state_nxt     = ACCEPT;
               end else do_reduce = 1'b1;
            end else if (reduce_pend) begin
               do_reduce = 1'b1;
            end else if (op_full) begin
               err_set = 1'b1;
            end else begin
               op_push   = 1'b1;
               op_din    = pend_op;
               state_nxt = ACCEPT;
            end
         end
         FINAL: begin
            if (op_empty) begin
               state_nxt = DONE;
               if (val_count != CW'(1)) begin
                  err_set = 1'b1;
                  err_new = ERR_SYNTAX;
               end
            end else if (op_top == OP_LPAR) begin
               err_set = 1'b1;
               err_new = ERR_PAREN;
            end else do_reduce = 1'b1;
         end
         DRAIN: if (fire && in_data == CH_EQ) state_nxt = DONE;
         DONE:  if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // One reduction collapses top two values into one, so the value stack never grows here.
      if (do_reduce) begin
         if (val_count < CW'(2)) begin
            err_set = 1'b1;
            err_new = ERR_SYNTAX;
         end else begin
            op_pop  = 1'b1;
            val_pop = 1'b1;
            val_wr  = 1'b1;
            val_din = red_val;
         end
      end

      if (err_set) state_nxt = (state == FINAL) ? DONE : DRAIN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         prev_digit <= 1'b0;
         pend_op    <= OP_ADD;
         pend_rpar  <= 1'b0;
         err_valid  <= 1'b0;
         err_q      <= ERR_OVERFLOW;
      end else begin
         state      <= state_nxt;
         prev_digit <= digit_nxt;
         pend_op    <= pend_op_nxt;
         pend_rpar  <= pend_rpar_nxt;
         if (state == IDLE) begin
            err_valid <= 1'b0;
         end else if (err_set && !err_valid) begin
            err_valid <= 1'b1;
            err_q     <= err_new;
         end
      end
   end

endmodule

// File: tb/tb_aec_stream_eval.sv
// Bench for aec_stream_eval: directed cases on three parameterisations plus
// random well-formed expressions scored against a grammar-level evaluator.
module tb_aec_stream_eval;

   localparam int W     = 16;
   localparam int LIMIT = 100;

   logic         clk = 1'b0;
   logic         rst;
   logic         iv   [3];
   logic [7:0]   id   [3];
   logic         ordy [3];
   logic         ir   [3];
   logic         ov   [3];
   logic [W-1:0] res  [3];
   logic         oe   [3];
   logic [1:0]   ec   [3];

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   aec_stream_eval #(.DATA_W(W), .DEPTH(16), .MULTI_DIGIT(1)) u_main (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]), .out_err(oe[0]), .err_code(ec[0]));
   aec_stream_eval #(.DATA_W(W), .DEPTH(4), .MULTI_DIGIT(1)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]), .out_err(oe[1]), .err_code(ec[1]));
   aec_stream_eval #(.DATA_W(W), .DEPTH(16), .MULTI_DIGIT(0)) u_md0 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .result(res[2]), .out_err(oe[2]), .err_code(ec[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int u = 0; u < 3; u++) begin
         iv[u]   = 1'b0;
         ordy[u] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_char(input int u, input logic [7:0] c, output int waits);
      waits = 0;
      @(negedge clk);
      iv[u] = 1'b1;
      id[u] = c;
      while (ir[u] !== 1'b1 && waits < LIMIT) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= LIMIT) begin
         n_cmp++;
         n_mis++;
         $error("FAIL accept_timeout: char 0x%0h not accepted after %0d cycles", c, waits);
      end
      @(posedge clk);
      #1;
      iv[u] = 1'b0;
   endtask

   task automatic run_expr(input int u, input string s, input int gap_max,
                           output int lat, output int late_waits);
      int w;
      late_waits = 0;
      for (int i = 0; i < s.len(); i++) begin
         repeat ($urandom_range(0, gap_max)) @(negedge clk);
         send_char(u, s[i], w);
         if (i > 0) late_waits += w;
      end
      lat = 0;
      while (ov[u] !== 1'b1 && lat < LIMIT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (lat >= LIMIT) begin
         n_cmp++;
         n_mis++;
         $error("FAIL result_timeout: '%s' gave no out_valid within %0d cycles", s, LIMIT);
      end
   endtask

   task automatic take(input int u);
      @(negedge clk);
      ordy[u] = 1'b1;
      @(posedge clk);
      #1;
      ordy[u] = 1'b0;
      check("out_valid drops after take", 32'(ov[u]), 0);
   endtask

   task automatic eval(input int u, input string s, input logic [W-1:0] exp_r, input logic exp_e,
                       input logic [1:0] exp_c, input int gap_max, output int lat, output int late_waits);
      run_expr(u, s, gap_max, lat, late_waits);
      check($sformatf("'%s' result", s), 32'(res[u]), 32'(exp_r));
      check($sformatf("'%s' out_err", s), 32'(oe[u]), 32'(exp_e));
      check($sformatf("'%s' err_code", s), 32'(ec[u]), 32'(exp_c));
      if (lat >= LIMIT) do_reset();
      else take(u);
   endtask

   // Reference model: expressions are built from the grammar and valued as they are built.
   function automatic string gen_number(output logic [W-1:0] v);
      string s = "";
      int    n = $urandom_range(1, 5);
      int    d;
      v = '0;
      for (int i = 0; i < n; i++) begin
         d = $urandom_range(0, 15);
         v = W'(v * 16 + d);
         s = {s, $sformatf("%0h", d)};
      end
      return s;
   endfunction

   function automatic string gen_inner(output logic [W-1:0] v);
      string s = "", t, q;
      logic [W-1:0] term, f;
      int nt = $urandom_range(1, 3);
      v = '0;
      for (int i = 0; i < nt; i++) begin
         t = gen_number(term);
         for (int j = 0; j < $urandom_range(0, 2); j++) begin
            q = gen_number(f);
            t = {t, "*", q};
            term = W'(term * f);
         end
         if (i == 0) begin
            s = t;
            v = term;
         end else if ($urandom_range(0, 1) == 1) begin
            s = {s, "+", t};
            v = W'(v + term);
         end else begin
            s = {s, "-", t};
            v = W'(v - term);
         end
      end
      return s;
   endfunction

   function automatic string gen_factor(output logic [W-1:0] v);
      string s;
      if ($urandom_range(0, 2) == 0) begin
         s = gen_inner(v);
         return {"(", s, ")"};
      end
      return gen_number(v);
   endfunction

   function automatic string gen_outer(output logic [W-1:0] v);
      string s = "", t, q;
      logic [W-1:0] term, f;
      int nt = $urandom_range(1, 3);
      v = '0;
      for (int i = 0; i < nt; i++) begin
         t = gen_factor(term);
         for (int j = 0; j < $urandom_range(0, 2); j++) begin
            q = gen_factor(f);
            t = {t, "*", q};
            term = W'(term * f);
         end
         if (i == 0) begin
            s = t;
            v = term;
         end else if ($urandom_range(0, 1) == 1) begin
            s = {s, "+", t};
            v = W'(v + term);
         end else begin
            s = {s, "-", t};
            v = W'(v - term);
         end
      end
      return s;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, lw, w;
      logic [W-1:0] v;
      string s;

      rst = 1'b1;
      for (int u = 0; u < 3; u++) begin
         iv[u]   = 1'b0;
         id[u]   = 8'h00;
         ordy[u] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) check($sformatf("in_ready low in reset [%0d]", u), 32'(ir[u]), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset in_ready", 32'(ir[0]), 0);
      check("reset out_valid", 32'(ov[0]), 0);
      check("reset result", 32'(res[0]), 0);
      check("reset out_err", 32'(oe[0]), 0);
      check("reset err_code", 32'(ec[0]), 0);
      @(posedge clk);
      #1;
      check("in_ready after IDLE", 32'(ir[0]), 1);

      eval(0, "3+4*2=", 16'h000b, 1'b0, 2'd0, 0, lat, lw);
      check("'3+4*2=' latency", lat, 3);
      eval(0, "(3+4)*2=", 16'h000e, 1'b0, 2'd0, 0, lat, lw);
      check("'(3+4)*2=' latency", lat, 2);
      eval(0, "f*(1+2)-5=", 16'h0028, 1'b0, 2'd0, 1, lat, lw);
      check("'f*(1+2)-5=' latency", lat, 2);
      eval(0, "1=", 16'h0001, 1'b0, 2'd0, 0, lat, lw);
      check("'1=' latency", lat, 1);
      eval(0, "2-5=", 16'hfffd, 1'b0, 2'd0, 0, lat, lw);
      eval(0, "ff+1=", 16'h0100, 1'b0, 2'd0, 0, lat, lw);
      eval(0, "12345=", 16'h2345, 1'b0, 2'd0, 0, lat, lw);
      eval(0, "(1+2=", 16'h0000, 1'b1, 2'd2, 0, lat, lw);
      eval(0, "1)=", 16'h0000, 1'b1, 2'd2, 0, lat, lw);
      eval(0, "1+g+2=", 16'h0000, 1'b1, 2'd1, 0, lat, lw);
      check("'1+g+2=' chars accepted without stall", lw, 0);
      eval(0, "1+=", 16'h0000, 1'b1, 2'd3, 0, lat, lw);
      eval(0, "=", 16'h0000, 1'b1, 2'd3, 0, lat, lw);

      eval(1, "((((1))))=", 16'h0001, 1'b0, 2'd0, 0, lat, lw);
      eval(1, "(((((1)))))=", 16'h0000, 1'b1, 2'd0, 0, lat, lw);
      eval(2, "12=", 16'h0000, 1'b1, 2'd3, 0, lat, lw);
      eval(2, "1+2*3=", 16'h0007, 1'b0, 2'd0, 0, lat, lw);

      run_expr(0, "7*3=", 0, lat, lw);
      check("hold result", 32'(res[0]), 32'h15);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold out_valid c%0d", k), 32'(ov[0]), 1);
         check($sformatf("hold result c%0d", k), 32'(res[0]), 32'h15);
         check($sformatf("hold in_ready c%0d", k), 32'(ir[0]), 0);
      end
      take(0);

      s = "1+2*(";
      for (int i = 0; i < s.len(); i++) send_char(0, s[i], w);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("in_ready gated by rst", 32'(ir[0]), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      eval(0, "1+1=", 16'h0002, 1'b0, 2'd0, 0, lat, lw);

      for (int k = 0; k < 40; k++) begin
         s = gen_outer(v);
         eval(0, {s, "="}, v, 1'b0, 2'd0, 2, lat, lw);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
